// File: rtl/tm1640_rx.sv
// rtl/tm1640_rx.sv - TM1640 two-wire link receiver with grid RAM and display-control state
// Oversamples tm_clk/tm_din in the clk domain and decodes commands into a 16-byte grid RAM.

module tm1640_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int GRIDS       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tm_clk,
    input  logic       tm_din,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       wr_strobe,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       disp_on,
    output logic [2:0] brightness,
    output logic       frame_done,
    output logic       proto_err
);

    localparam logic [4:0] GRIDS_L = 5'(GRIDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
        S_WAIT_STOP
    } state_t;

    // Synchronizers idle high so a released reset never fakes an edge on an idle bus.
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] din_sync_q;
    logic                   sc;
    logic                   sd;
    logic                   sc_q;
    logic                   sd_q;

    assign sc = clk_sync_q[SYNC_STAGES-1];
    assign sd = din_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q <= '1;
            din_sync_q <= '1;
            sc_q       <= 1'b1;
            sd_q       <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], tm_clk};
            din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], tm_din};
            sc_q       <= sc;
            sd_q       <= sd;
        end
    end

    logic ev_start_d;
    logic ev_stop_d;
    logic ev_bit_d;
    logic ev_start_q;
    logic ev_stop_q;
    logic ev_bit_q;
    logic bit_val_q;

    always_comb begin
        ev_start_d = sc & sc_q & sd_q & ~sd;
        ev_stop_d  = sc & sc_q & ~sd_q & sd;
        ev_bit_d   = sc & ~sc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ev_start_q <= 1'b0;
            ev_stop_q  <= 1'b0;
            ev_bit_q   <= 1'b0;
            bit_val_q  <= 1'b0;
        end else begin
            ev_start_q <= ev_start_d;
            ev_stop_q  <= ev_stop_d;
            ev_bit_q   <= ev_bit_d;
            bit_val_q  <= sd;
        end
    end

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [6:0] sr_q, sr_d;
    logic [3:0] addr_q, addr_d;
    logic       auto_inc_q, auto_inc_d;
    logic       disp_on_q, disp_on_d;
    logic [2:0] brightness_q, brightness_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic [3:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       frame_done_q, frame_done_d;
    logic       proto_err_q, proto_err_d;
    logic [7:0] shift_byte;
    logic       ram_we;
    logic       addr_in_range;

    // sr holds the upper seven bits of the byte so far; the newest bit enters at the top.
    assign shift_byte    = {bit_val_q, sr_q};
    assign addr_in_range = ({1'b0, addr_q} < GRIDS_L);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sr_d         = sr_q;
        addr_d       = addr_q;
        auto_inc_d   = auto_inc_q;
        disp_on_d    = disp_on_q;
        brightness_d = brightness_q;
        wr_strobe_d  = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        proto_err_d  = 1'b0;
        ram_we       = 1'b0;

        if (ev_start_q) begin
            cnt_d   = 3'd0;
            state_d = S_CMD;
        end else if (ev_stop_q) begin
            if (state_q != S_IDLE) begin
                state_d     = S_IDLE;
                cnt_d       = 3'd0;
                proto_err_d = (cnt_q != 3'd0);
            end
        end else if (ev_bit_q && state_q != S_IDLE) begin
            sr_d  = shift_byte[7:1];
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                case (state_q)
                    S_CMD: begin
                        state_d = S_WAIT_STOP;
                        case (shift_byte[7:6])
                            2'b01: auto_inc_d = ~shift_byte[2];
                            2'b11: begin
                                addr_d  = shift_byte[3:0];
                                state_d = S_DATA;
                            end
                            2'b10: begin
                                disp_on_d    = shift_byte[3];
                                brightness_d = shift_byte[2:0];
                                frame_done_d = 1'b1;
                            end
                            default: proto_err_d = 1'b1;
                        endcase
                    end
                    S_DATA: begin
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = addr_q;
                        wr_data_d   = shift_byte;
                        ram_we      = addr_in_range;
                        if (auto_inc_q) begin
                            addr_d = addr_q + 4'd1;
                        end
                    end
                    S_WAIT_STOP: proto_err_d = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 3'd0;
            sr_q         <= 7'd0;
            addr_q       <= 4'd0;
            auto_inc_q   <= 1'b1;
            disp_on_q    <= 1'b0;
            brightness_q <= 3'd0;
            wr_strobe_q  <= 1'b0;
            wr_addr_q    <= 4'd0;
            wr_data_q    <= 8'd0;
            frame_done_q <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            addr_q       <= addr_d;
            auto_inc_q   <= auto_inc_d;
            disp_on_q    <= disp_on_d;
            brightness_q <= brightness_d;
            wr_strobe_q  <= wr_strobe_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            proto_err_q  <= proto_err_d;
        end
    end

    // Addresses at or above GRIDS are never written, but the read mux still forces them to zero.
    logic [7:0] ram_q [16];
    logic [7:0] rd_data_q;
    logic       rd_in_range;

    assign rd_in_range = ({1'b0, rd_addr} < GRIDS_L);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                ram_q[i] <= 8'h00;
            end
            rd_data_q <= 8'h00;
        end else begin
            if (ram_we) begin
                ram_q[addr_q] <= shift_byte;
            end
            rd_data_q <= rd_in_range ? ram_q[rd_addr] : 8'h00;
        end
    end

    assign rd_data    = rd_data_q;
    assign wr_strobe  = wr_strobe_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign disp_on    = disp_on_q;
    assign brightness = brightness_q;
    assign frame_done = frame_done_q;
    assign proto_err  = proto_err_q;

endmodule
